sprite_row_reader: RTL and testbench

- Consumer side of the block-sprite ROM interface.
- Accepts a draw request for a block style, a start row and a row count. Drives the ROM address, captures each 32-bit row word, and serialises it into 2-bit palette indices, one pixel per accepted beat.
- Sits between the playfield renderer, which issues requests, and the pixel/colour mapper, which consumes the pixel stream under backpressure.

---
 rtl/sprite_row_reader_if.sv | 32 +++
 rtl/sprite_row_reader.sv | 94 +++++++++
 tb/tb_sprite_row_reader.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_row_reader_if.sv
// Bundles the request handshake, the sprite ROM bus and the pixel stream of
// the sprite row reader. The reader takes the slave view; the renderer, ROM
// and colour mapper together form the master view.
interface sprite_row_reader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int PIX_BITS   = 2
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic [1:0]            REQ_STYLE;
  logic [ADDR_WIDTH-3:0] REQ_ROW;
  logic [ADDR_WIDTH-3:0] REQ_COUNT;
  logic [ADDR_WIDTH-1:0] SPRITE_ADDR;
  logic [DATA_WIDTH-1:0] SPRITE_DATA;
  logic                  PIX_VALID;
  logic                  PIX_READY;
  logic [PIX_BITS-1:0]   PIX_COLOR;
  logic                  PIX_EOL;
  logic                  PIX_LAST;
  logic                  BUSY;

  modport slave (
    input  REQ_VALID, REQ_STYLE, REQ_ROW, REQ_COUNT, SPRITE_DATA, PIX_READY,
    output REQ_READY, SPRITE_ADDR, PIX_VALID, PIX_COLOR, PIX_EOL, PIX_LAST, BUSY
  );

  modport master (
    output REQ_VALID, REQ_STYLE, REQ_ROW, REQ_COUNT, SPRITE_DATA, PIX_READY,
    input  REQ_READY, SPRITE_ADDR, PIX_VALID, PIX_COLOR, PIX_EOL, PIX_LAST, BUSY
  );
endinterface

// File: rtl/sprite_row_reader.sv
// Sprite row reader: fetches sprite rows from the block ROM and streams them
// out as palette indices, one pixel per accepted beat, MSB pair first.
module sprite_row_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int PIX_BITS   = 2
) (
  input logic               Clk,
  input logic               Reset,
  sprite_row_reader_if.slave bus
);

  localparam int PIXELS   = DATA_WIDTH / PIX_BITS;
  localparam int IDX_BITS = $clog2(PIXELS);
  localparam int ROW_BITS = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] shift;
  logic [IDX_BITS-1:0]   idx;
  logic [ROW_BITS-1:0]   rows_rem;

  logic at_eol;
  logic at_last;
  logic take_req;

  // Status and stream outputs decoded from registered state; REQ_READY also
  // opens during an accepted final beat so a queued request costs no extra cycle.
  always_comb begin
    at_eol          = (state == SHIFT) && (idx == IDX_BITS'(PIXELS - 1));
    at_last         = at_eol && (rows_rem == '0);
    bus.REQ_READY   = (state == IDLE) || (at_last && bus.PIX_READY);
    take_req        = bus.REQ_VALID && bus.REQ_READY;
    bus.SPRITE_ADDR = addr;
    bus.PIX_VALID   = (state == SHIFT);
    bus.PIX_COLOR   = shift[DATA_WIDTH-1 -: PIX_BITS];
    bus.PIX_EOL     = at_eol;
    bus.PIX_LAST    = at_last;
    bus.BUSY        = (state != IDLE);
  end

  // Request/fetch/shift sequencer; the row field of addr doubles as the
  // current row counter, so wrapping modulo 16 leaves the style bits alone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      addr     <= '0;
      shift    <= '0;
      idx      <= '0;
      rows_rem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_req) begin
            addr     <= {bus.REQ_STYLE, bus.REQ_ROW};
            rows_rem <= bus.REQ_COUNT;
            state    <= FETCH;
          end
        end
        FETCH: begin
          shift <= bus.SPRITE_DATA;
          idx   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (bus.PIX_READY) begin
            if (!at_eol) begin
              shift <= shift << PIX_BITS;
              idx   <= idx + 1'b1;
            end else if (!at_last) begin
              addr[ROW_BITS-1:0] <= addr[ROW_BITS-1:0] + 1'b1;
              rows_rem           <= rows_rem - 1'b1;
              state              <= FETCH;
            end else if (take_req) begin
              addr     <= {bus.REQ_STYLE, bus.REQ_ROW};
              rows_rem <= bus.REQ_COUNT;
              state    <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_reader.sv
// Self-checking bench for sprite_row_reader: a ROM image in an array, a pixel
// model computed straight from the ROM words, and one task per scenario.
module tb_sprite_row_reader;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sprite_row_reader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .PIX_BITS(2)) bus ();

  sprite_row_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .PIX_BITS(2)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [31:0] rom [64];
  assign bus.SPRITE_DATA = rom[bus.SPRITE_ADDR];

  int total = 0;
  int bad   = 0;

  // Results of the last collect() call
  int         got_col[$];
  int         got_eol[$];
  int         got_last[$];
  logic [5:0] got_addr[$];
  int gaps, hold_bad, first_lat, timeout, rr_at_last, busy_after, post_valid;
  logic [5:0] post_addr;

  // Expected colour of beat i of a request: row i/16 after the start row
  // (mod 16), pixel i%16 counted from the MSB end of the ROM word.
  function automatic int exp_pix(int st, int rw, int i);
    int a;
    a = st * 16 + ((rw + i / 16) % 16);
    return int'((rom[a] >> (30 - 2 * (i % 16))) & 32'h3);
  endfunction

  task automatic issue(input int st, input int rw, input int cnt);
    int n;
    n = 0;
    @(posedge Clk); #1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_STYLE = 2'(st);
    bus.REQ_ROW   = 4'(rw);
    bus.REQ_COUNT = 4'(cnt);
    #1;
    while (!bus.REQ_READY && n < 50) begin
      @(posedge Clk); #2;
      n++;
    end
  endtask

  // Runs one request from its acceptance edge to the final beat.
  // mode 0: ready always; 1: toggle with 5-cycle stall on beat 2;
  // 2: random ready; 3: ready always, next request offered on the last beat.
  task automatic collect(input int mode);
    int cyc, stall, r, held;
    bit done;
    got_col.delete(); got_eol.delete(); got_last.delete(); got_addr.delete();
    gaps = 0; hold_bad = 0; first_lat = -1; timeout = 0; rr_at_last = 0;
    cyc = 0; stall = 0; held = -1; done = 1'b0;
    while (!done && cyc < 2000) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_STYLE = 2'($urandom);
        bus.REQ_ROW   = 4'($urandom);
        bus.REQ_COUNT = 4'($urandom);
      end
      case (mode)
        1: begin
          if (bus.PIX_VALID && got_col.size() == 2 && stall < 5) begin
            r = 0;
            stall++;
          end else begin
            r = cyc % 2;
          end
        end
        2:       r = ($urandom_range(0, 3) != 0) ? 1 : 0;
        default: r = 1;
      endcase
      bus.PIX_READY = r[0];
      if (mode == 3 && bus.PIX_VALID && bus.PIX_LAST) begin
        bus.REQ_VALID = 1'b1;
        bus.REQ_STYLE = 2'd0;
        bus.REQ_ROW   = 4'd0;
        bus.REQ_COUNT = 4'd0;
      end
      #1;
      if (bus.PIX_VALID) begin
        if (first_lat < 0) first_lat = cyc;
        if (held >= 0 && int'(bus.PIX_COLOR) != held) hold_bad++;
        held = -1;
        if (r != 0) begin
          got_col.push_back(int'(bus.PIX_COLOR));
          got_eol.push_back(int'(bus.PIX_EOL));
          got_last.push_back(int'(bus.PIX_LAST));
          if (bus.PIX_LAST) begin
            done = 1'b1;
            rr_at_last = int'(bus.REQ_READY);
          end
        end else begin
          held = int'(bus.PIX_COLOR);
        end
      end else begin
        if (bus.BUSY) got_addr.push_back(bus.SPRITE_ADDR);
        if (got_col.size() > 0) gaps++;
      end
    end
    if (!done) timeout = 1;
    @(posedge Clk); #1;
    busy_after = int'(bus.BUSY);
    post_addr  = bus.SPRITE_ADDR;
    post_valid = int'(bus.PIX_VALID);
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_STYLE = 2'd1; bus.REQ_ROW = 4'd1; bus.REQ_COUNT = 4'd0;
    bus.PIX_READY = 1'b1;
    #2;
    total++;
    if (bus.REQ_READY !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready: got %b want 1", bus.REQ_READY);
    end
    total++;
    if ({bus.BUSY, bus.PIX_VALID, bus.PIX_COLOR, bus.PIX_EOL, bus.PIX_LAST, bus.SPRITE_ADDR} !== 12'h0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b valid=%b col=%0d eol=%b last=%b addr=%h want all 0",
               bus.BUSY, bus.PIX_VALID, bus.PIX_COLOR, bus.PIX_EOL, bus.PIX_LAST, bus.SPRITE_ADDR);
    end
    @(posedge Clk); @(posedge Clk); #1;
    total++;
    if (bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_no_transfer: busy=%b want 0", bus.BUSY);
    end
    bus.REQ_VALID = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic test_single();
    issue(1, 1, 0);
    collect(0);
    total++;
    if (timeout != 0 || got_col.size() != 16) begin
      bad++; $display("FAIL single_count: got %0d beats (timeout=%0d) want 16", got_col.size(), timeout);
    end
    total++;
    if (got_addr.size() < 1 || got_addr[0] !== 6'h11) begin
      bad++; $display("FAIL single_addr: got %0d fetches first=%h want 11", got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 6'h0);
    end
    total++;
    if (first_lat != 2) begin
      bad++; $display("FAIL single_latency: pixel 0 %0d cycles after accept, want 2", first_lat);
    end
    for (int i = 0; i < got_col.size(); i++) begin
      total++;
      if (got_col[i] != exp_pix(1, 1, i) || got_eol[i] != int'(i == 15) || got_last[i] != int'(i == 15)) begin
        bad++; $display("FAIL single_beat%0d: got col=%0d eol=%0d last=%0d want col=%0d eol=%0d last=%0d",
                        i, got_col[i], got_eol[i], got_last[i], exp_pix(1, 1, i), int'(i == 15), int'(i == 15));
      end
    end
    total++;
    if (busy_after != 0) begin
      bad++; $display("FAIL single_busy_after: got %0d want 0", busy_after);
    end
  endtask

  task automatic test_two_rows();
    issue(3, 1, 1);
    collect(0);
    total++;
    if (timeout != 0 || got_col.size() != 32) begin
      bad++; $display("FAIL two_rows_count: got %0d beats want 32", got_col.size());
    end
    total++;
    if (got_addr.size() != 2 || got_addr[0] !== 6'h31 || got_addr[1] !== 6'h32) begin
      bad++; $display("FAIL two_rows_addr: got %0d fetches, want 31 then 32", got_addr.size());
    end
    total++;
    if (gaps != 1) begin
      bad++; $display("FAIL two_rows_gap: got %0d idle cycles between rows want 1", gaps);
    end
    for (int i = 0; i < got_col.size(); i++) begin
      total++;
      if (got_col[i] != exp_pix(3, 1, i) || got_eol[i] != int'(i % 16 == 15) || got_last[i] != int'(i == 31)) begin
        bad++; $display("FAIL two_rows_beat%0d: got col=%0d eol=%0d last=%0d want col=%0d eol=%0d last=%0d",
                        i, got_col[i], got_eol[i], got_last[i], exp_pix(3, 1, i), int'(i % 16 == 15), int'(i == 31));
      end
    end
  endtask

  task automatic test_wrap();
    issue(2, 15, 1);
    collect(0);
    total++;
    if (got_addr.size() != 2 || got_addr[0] !== 6'h2F || got_addr[1] !== 6'h20) begin
      bad++; $display("FAIL wrap_addr: got %0d fetches, want 2F then 20", got_addr.size());
    end
    foreach (got_addr[k]) begin
      total++;
      if (got_addr[k][5:4] !== 2'b10) begin
        bad++; $display("FAIL wrap_style: fetch %0d style %b want 10", k, got_addr[k][5:4]);
      end
    end
    total++;
    if (got_col.size() != 32) begin
      bad++; $display("FAIL wrap_count: got %0d beats want 32", got_col.size());
    end
    for (int i = 0; i < got_col.size(); i++) begin
      total++;
      if (got_col[i] != exp_pix(2, 15, i)) begin
        bad++; $display("FAIL wrap_beat%0d: got col=%0d want %0d", i, got_col[i], exp_pix(2, 15, i));
      end
    end
  endtask

  task automatic test_backpressure();
    issue(1, 1, 0);
    collect(1);
    total++;
    if (timeout != 0 || got_col.size() != 16) begin
      bad++; $display("FAIL bp_count: got %0d beats want 16", got_col.size());
    end
    total++;
    if (hold_bad != 0) begin
      bad++; $display("FAIL bp_hold: colour changed %0d times while stalled, want 0", hold_bad);
    end
    for (int i = 0; i < got_col.size(); i++) begin
      total++;
      if (got_col[i] != exp_pix(1, 1, i) || got_last[i] != int'(i == 15)) begin
        bad++; $display("FAIL bp_beat%0d: got col=%0d last=%0d want col=%0d last=%0d",
                        i, got_col[i], got_last[i], exp_pix(1, 1, i), int'(i == 15));
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1, 1, 0);
    collect(3);
    total++;
    if (rr_at_last != 1) begin
      bad++; $display("FAIL b2b_ready: REQ_READY on last beat %0d want 1", rr_at_last);
    end
    total++;
    if (post_addr !== 6'h00 || post_valid != 0 || busy_after != 1) begin
      bad++; $display("FAIL b2b_fetch: got addr=%h valid=%0d busy=%0d want addr=00 valid=0 busy=1",
                      post_addr, post_valid, busy_after);
    end
    collect(0);
    total++;
    if (first_lat != 1 || got_col.size() != 16) begin
      bad++; $display("FAIL b2b_second: first beat at %0d with %0d beats, want 1 and 16", first_lat, got_col.size());
    end
    for (int i = 0; i < got_col.size(); i++) begin
      total++;
      if (got_col[i] != exp_pix(0, 0, i)) begin
        bad++; $display("FAIL b2b_beat%0d: got col=%0d want %0d", i, got_col[i], exp_pix(0, 0, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, nb, seen;
    issue(2, 3, 3);
    bus.PIX_READY = 1'b1;
    n = 0; nb = 0; seen = 0;
    while (n < 200 && seen == 0) begin
      @(posedge Clk); #1;
      n++;
      if (n == 1) bus.REQ_VALID = 1'b0;
      if (bus.PIX_VALID) begin
        if (nb == 7) seen = 1;
        else nb++;
      end
    end
    total++;
    if (seen == 0) begin
      bad++; $display("FAIL rst_mid_reach: beat 7 not presented, got %0d beats", nb);
    end
    #1 Reset = 1'b1;
    #1;
    total++;
    if ({bus.BUSY, bus.PIX_VALID, bus.PIX_COLOR, bus.PIX_EOL, bus.PIX_LAST, bus.SPRITE_ADDR} !== 12'h0 || bus.REQ_READY !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_async: got busy=%b valid=%b col=%0d eol=%b last=%b addr=%h rdy=%b want zeros rdy=1",
               bus.BUSY, bus.PIX_VALID, bus.PIX_COLOR, bus.PIX_EOL, bus.PIX_LAST, bus.SPRITE_ADDR, bus.REQ_READY);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      total++;
      if (bus.PIX_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
        bad++; $display("FAIL rst_mid_quiet%0d: valid=%b busy=%b want 0 0", c, bus.PIX_VALID, bus.BUSY);
      end
    end
    issue(1, 1, 0);
    collect(0);
    total++;
    if (got_col.size() != 16) begin
      bad++; $display("FAIL rst_mid_restart_count: got %0d beats want 16", got_col.size());
    end
    for (int i = 0; i < got_col.size(); i++) begin
      total++;
      if (got_col[i] != exp_pix(1, 1, i)) begin
        bad++; $display("FAIL rst_mid_restart_beat%0d: got col=%0d want %0d", i, got_col[i], exp_pix(1, 1, i));
      end
    end
  endtask

  task automatic test_random();
    int st, rw, cnt, nbe;
    for (int t = 0; t < 5; t++) begin
      st  = $urandom_range(0, 3);
      rw  = $urandom_range(0, 15);
      cnt = (t == 0) ? 15 : $urandom_range(0, 4);
      nbe = 16 * (cnt + 1);
      issue(st, rw, cnt);
      collect(2);
      total++;
      if (timeout != 0 || got_col.size() != nbe) begin
        bad++; $display("FAIL rand%0d_count: got %0d beats want %0d", t, got_col.size(), nbe);
      end
      for (int i = 0; i < got_col.size(); i++) begin
        total++;
        if (got_col[i] != exp_pix(st, rw, i) || got_eol[i] != int'(i % 16 == 15) || got_last[i] != int'(i == nbe - 1)) begin
          bad++; $display("FAIL rand%0d_beat%0d: got col=%0d eol=%0d last=%0d want col=%0d eol=%0d last=%0d",
                          t, i, got_col[i], got_eol[i], got_last[i], exp_pix(st, rw, i), int'(i % 16 == 15), int'(i == nbe - 1));
        end
      end
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 64; i++) rom[i] = $urandom;
    rom[6'h11] = 32'h8F00_0000;
    rom[6'h31] = 32'h8FFF_FFFC;
    rom[6'h32] = 32'h8FFF_FFFC;
    rom[6'h2F] = 32'hAAAA_AAAA;
    rom[6'h20] = 32'h9555_5555;
    rom[6'h00] = 32'hAAAA_AAAA;
    test_reset();
    test_single();
    test_two_rows();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
